// File: rtl/or_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// or_arbiter_pkg
// Shared definitions for the round-robin OR arbiter:
//   state_t   - FSM state encoding (IDLE=0, COMPUTE=1, HOLD=2; 3 is unused)
//   tag_width - width of a requester index for n requesters (minimum 1 bit)
// -----------------------------------------------------------------------------
package or_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  // ceil(log2(n)), but never below 1 so a tag port always exists.
  function automatic int tag_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/Or.sv
// -----------------------------------------------------------------------------
// Or
// Parameterized bitwise OR datapath shared by all requesters of or_arbiter.
// Ports:
//   a, b : WIDTH-bit operands
//   y    : WIDTH-bit result, a | b (purely combinational)
// -----------------------------------------------------------------------------
module Or #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a | b;

endmodule

// File: rtl/or_arbiter.sv
// -----------------------------------------------------------------------------
// or_arbiter
// Round-robin arbiter sharing one Or datapath among NREQ requesters. A granted
// request's operands are captured, ORed in the COMPUTE cycle, and the result is
// held with the requester's tag until the consumer takes it.
//
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   req_valid[NREQ]       - requester i presents operands
//   req_ready[NREQ]       - one-hot/zero; requester i accepted this cycle
//   req_a, req_b          - packed operands, requester i at [i*WIDTH +: WIDTH]
//   res_valid, res_ready  - result channel handshake
//   res_data, res_tag     - registered result and producing requester index
//   busy                  - state is not IDLE
//   dbg_state             - current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. req_ready is combinational from req_valid/res_ready, so a requester must
// not derive req_valid from req_ready. res_valid/res_data/res_tag stay stable
// while res_valid is high and res_ready is low.
// -----------------------------------------------------------------------------
module or_arbiter
  import or_arbiter_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int TAGW  = tag_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [TAGW-1:0]       res_tag,
  output logic                  busy,
  output state_t                dbg_state
);

  state_t            state_q, state_d;
  logic [TAGW-1:0]   ptr_q;
  logic [TAGW-1:0]   gnt_q;
  logic [WIDTH-1:0]  op_a_q, op_b_q;
  logic [WIDTH-1:0]  res_data_q;
  logic [TAGW-1:0]   res_tag_q;
  logic              res_valid_q;

  logic [TAGW-1:0]   grant;
  logic              any_req;
  logic              accept_win;
  logic              accept;
  logic [WIDTH-1:0]  or_y;

  // Round-robin search: first valid requester starting at ptr, wrapping.
  // The double wrap keeps idx in range even for an out-of-range ptr value.
  always_comb begin
    any_req = 1'b0;
    grant   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        grant   = TAGW'(idx);
      end
    end
  end

  // Accept while idle, or while the held result is leaving this same edge.
  assign accept_win = (state_q == ST_IDLE) ||
                      ((state_q == ST_HOLD) && res_ready);
  assign accept     = accept_win && any_req && !reset;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_COMPUTE;
      ST_COMPUTE: state_d = ST_HOLD;
      ST_HOLD:    if (res_ready) state_d = accept ? ST_COMPUTE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  Or #(.WIDTH(WIDTH)) u_or (
    .a (op_a_q),
    .b (op_b_q),
    .y (or_y)
  );

  // Operand capture, pointer update and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      gnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        op_a_q <= req_a[int'(grant)*WIDTH +: WIDTH];
        op_b_q <= req_b[int'(grant)*WIDTH +: WIDTH];
        gnt_q  <= grant;
        ptr_q  <= (int'(grant) == NREQ-1) ? '0 : grant + TAGW'(1);
      end
      if (state_q == ST_COMPUTE) begin
        res_data_q  <= or_y;
        res_tag_q   <= gnt_q;
        res_valid_q <= 1'b1;
      end else if ((state_q == ST_HOLD) && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_or_arbiter.sv
// -----------------------------------------------------------------------------
// tb_or_arbiter
// Drives a 4-requester and a 3-requester or_arbiter side by side. A transaction
// timeline model (grant at cycle c, result visible from c+2 until taken) predicts
// req_ready, res_valid, busy, res_data and res_tag every cycle; directed
// sequences cover the listed scenarios, then a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_or_arbiter;
  import or_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [3:0]  rv4, rdy4;
  logic [31:0] a4, b4;
  logic        rr4, vo4, busy4;
  logic [7:0]  d4;
  logic [1:0]  t4;
  state_t      st4;

  logic [2:0]  rv3, rdy3;
  logic [23:0] a3, b3;
  logic        rr3, vo3, busy3;
  logic [7:0]  d3;
  logic [1:0]  t3;
  state_t      st3;

  or_arbiter #(.WIDTH(8), .NREQ(4)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(rv4), .req_ready(rdy4),
    .req_a(a4), .req_b(b4), .res_valid(vo4), .res_ready(rr4),
    .res_data(d4), .res_tag(t4), .busy(busy4), .dbg_state(st4)
  );

  or_arbiter #(.WIDTH(8), .NREQ(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(rdy3),
    .req_a(a3), .req_b(b3), .res_valid(vo3), .res_ready(rr3),
    .res_data(d3), .res_tag(t3), .busy(busy3), .dbg_state(st3)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ptr_m[2];
  int acc_m[2];
  logic [11:0] exp_q4[$];   // {tag[3:0], data[7:0]} in grant order
  logic [11:0] exp_q3[$];
  int tlog4[$], tlog3[$];   // tags of handed-off results
  int dlog4[$];             // data of handed-off results
  int hcyc4[$];             // handoff cycles

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Compare one DUT against the model for the current cycle, then advance the
  // model to reflect the coming clock edge.
  task automatic check_dut(input int d);
    int n, g, qs;
    logic [3:0] v, rdy, exp_rdy;
    logic [31:0] a, b;
    logic rr, vo, bz, shown, win;
    logic [7:0] dat;
    logic [1:0] tg;
    logic [11:0] head, item;
    string p;
    head = '0;
    if (d == 0) begin
      n = 4; v = rv4; a = a4; b = b4; rr = rr4; rdy = rdy4;
      vo = vo4; dat = d4; tg = t4; bz = busy4; qs = exp_q4.size(); p = "u4";
      if (qs > 0) head = exp_q4[0];
    end else begin
      n = 3; v = {1'b0, rv3}; a = {8'h00, a3}; b = {8'h00, b3}; rr = rr3;
      rdy = {1'b0, rdy3}; vo = vo3; dat = d3; tg = t3; bz = busy3;
      qs = exp_q3.size(); p = "u3";
      if (qs > 0) head = exp_q3[0];
    end

    shown = (qs > 0) && (cyc >= acc_m[d] + 2);
    win   = (qs == 0) || (shown && rr);
    g = -1;
    for (int k = 0; k < n; k++) begin
      int i;
      i = (ptr_m[d] + k) % n;
      if (g < 0 && v[i]) g = i;
    end
    exp_rdy = (win && g >= 0) ? 4'(1 << g) : 4'b0000;

    check({p, " req_ready"}, 32'(rdy), 32'(exp_rdy));
    check({p, " res_valid"}, 32'(vo), 32'(shown));
    check({p, " busy"}, 32'(bz), 32'(qs > 0));
    if (shown) begin
      check({p, " res_data"}, 32'(dat), 32'(head[7:0]));
      check({p, " res_tag"}, 32'(tg), 32'(head[11:8]));
    end

    if (shown && rr) begin
      if (d == 0) begin
        void'(exp_q4.pop_front());
        tlog4.push_back(int'(head[11:8]));
        dlog4.push_back(int'(head[7:0]));
        hcyc4.push_back(cyc);
      end else begin
        void'(exp_q3.pop_front());
        tlog3.push_back(int'(head[11:8]));
      end
    end
    if (win && g >= 0) begin
      item = {4'(g), a[g*8 +: 8] | b[g*8 +: 8]};
      if (d == 0) exp_q4.push_back(item);
      else        exp_q3.push_back(item);
      acc_m[d] = cyc;
      ptr_m[d] = (g + 1) % n;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Assert reset asynchronously mid-cycle with requests pending; every output
  // must clear at once and req_ready must stay low while reset is high.
  task automatic do_reset();
    rv4 = 4'hF;
    rv3 = 3'h7;
    reset = 1'b1;
    #1;
    check("rst u4 req_ready", 32'(rdy4), 32'h0);
    check("rst u4 res_valid", 32'(vo4), 32'h0);
    check("rst u4 res_data", 32'(d4), 32'h0);
    check("rst u4 res_tag", 32'(t4), 32'h0);
    check("rst u4 busy", 32'(busy4), 32'h0);
    check("rst u4 state", 32'(st4), 32'(ST_IDLE));
    check("rst u3 req_ready", 32'(rdy3), 32'h0);
    check("rst u3 res_valid", 32'(vo3), 32'h0);
    check("rst u3 busy", 32'(busy3), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rv4 = '0;
    rv3 = '0;
    exp_q4.delete();
    exp_q3.delete();
    ptr_m[0] = 0; ptr_m[1] = 0;
    acc_m[0] = 0; acc_m[1] = 0;
    cyc = 0;
  endtask

  task automatic clear_logs();
    tlog4.delete();
    tlog3.delete();
    dlog4.delete();
    hcyc4.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ones;
    rv4 = '0; a4 = '0; b4 = '0; rr4 = 1'b1;
    rv3 = '0; a3 = '0; b3 = '0; rr3 = 1'b1;
    #2;
    do_reset();

    // Single request from requester 2
    clear_logs();
    rv4 = 4'b0100; a4 = 32'h00F0_0000; b4 = 32'h000F_0000; rr4 = 1'b1;
    cycle();
    rv4 = '0;
    repeat (4) cycle();
    check("single count", 32'(tlog4.size()), 32'd1);
    if (tlog4.size() > 0) begin
      check("single tag", 32'(tlog4[0]), 32'd2);
      check("single data", 32'(dlog4[0]), 32'hFF);
      check("single handoff cycle", 32'(hcyc4[0]), 32'd2);
    end

    // Fairness with all requesters valid
    do_reset();
    clear_logs();
    rv4 = 4'hF; a4 = $urandom; b4 = $urandom; rr4 = 1'b1;
    repeat (13) cycle();
    rv4 = '0;
    repeat (3) cycle();
    check("fair count", 32'(tlog4.size()), 32'd7);
    for (int i = 0; i < 6; i++) begin
      if (i < tlog4.size()) check("fair tag order", 32'(tlog4[i]), 32'(i % 4));
      if (i + 1 < hcyc4.size()) check("fair spacing", 32'(hcyc4[i+1] - hcyc4[i]), 32'd2);
    end

    // Backpressure for 5 cycles, then simultaneous handoff and grant
    do_reset();
    clear_logs();
    rv4 = 4'b0001; a4 = 32'h0000_0081; b4 = 32'h0000_0018; rr4 = 1'b1;
    cycle();
    rv4 = 4'b0110; a4 = 32'h0000_3C00; b4 = 32'h0000_4200; rr4 = 1'b0;
    repeat (6) cycle();
    check("bp held data", 32'(d4), 32'h99);
    check("bp held tag", 32'(t4), 32'd0);
    rr4 = 1'b1;
    cycle();
    rv4 = '0;
    repeat (4) cycle();
    check("bp count", 32'(tlog4.size()), 32'd2);
    if (tlog4.size() > 1) begin
      check("bp first data", 32'(dlog4[0]), 32'h99);
      check("bp second tag", 32'(tlog4[1]), 32'd1);
      check("bp second data", 32'(dlog4[1]), 32'h7E);
    end

    // Pointer wrap on the 3-requester instance
    do_reset();
    clear_logs();
    rv3 = 3'b100; a3 = 24'h5A_0000; b3 = 24'h05_0000; rr3 = 1'b1;
    cycle();
    rv3 = '0;
    repeat (3) cycle();
    rv3 = 3'b101; a3 = 24'($urandom); b3 = 24'($urandom);
    repeat (3) cycle();
    rv3 = '0;
    repeat (4) cycle();
    check("wrap count", 32'(tlog3.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < tlog3.size()) check("wrap tag order", 32'(tlog3[i]), (i == 1) ? 32'd0 : 32'd2);

    // Reset while a result is held, then first grant searches from 0
    clear_logs();
    rv4 = 4'b1000; a4 = $urandom; b4 = $urandom; rr4 = 1'b0;
    cycle();
    rv4 = '0;
    repeat (2) cycle();
    check("pre-reset res_valid", 32'(vo4), 32'd1);
    do_reset();
    clear_logs();
    rv4 = 4'hF; rr4 = 1'b1;
    cycle();
    rv4 = '0;
    repeat (3) cycle();
    check("post-reset count", 32'(tlog4.size()), 32'd1);
    if (tlog4.size() > 0) check("post-reset first tag", 32'(tlog4[0]), 32'd0);

    // Request withdrawn while the arbiter computes
    clear_logs();
    rv4 = 4'b0001; a4 = $urandom; b4 = $urandom; rr4 = 1'b1;
    cycle();
    rv4 = 4'b0010;
    cycle();
    rv4 = '0;
    repeat (4) cycle();
    ones = 0;
    foreach (tlog4[i]) if (tlog4[i] == 1) ones++;
    check("withdrawn count", 32'(tlog4.size()), 32'd1);
    check("withdrawn tag1 results", 32'(ones), 32'd0);

    // Randomized traffic on both instances, with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      rv4 = 4'($urandom_range(0, 15));
      a4  = $urandom; b4 = $urandom;
      rr4 = ($urandom_range(0, 3) != 0);
      rv3 = 3'($urandom_range(0, 7));
      a3  = 24'($urandom); b3 = 24'($urandom);
      rr3 = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
